// File: rtl/aes256_round_key_store_if.sv
// Bundle between AES-256 key expansion / round datapath and the round key store.
// master drives capture and read requests; slave (the store) returns read data and status.
interface aes256_round_key_store_if #(
  parameter int RK_W  = 128,
  parameter int IDX_W = 4
);
  logic             load_start;
  logic [RK_W-1:0]  rk_in;
  logic             rk_in_valid;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic [RK_W-1:0]  rd_data;
  logic             rd_valid;
  logic             sched_ready;
  logic [IDX_W-1:0] capture_cnt;
  logic             err;

  modport master (
    output load_start, rk_in, rk_in_valid, rd_en, rd_idx,
    input  rd_data, rd_valid, sched_ready, capture_cnt, err
  );

  modport slave (
    input  load_start, rk_in, rk_in_valid, rd_en, rd_idx,
    output rd_data, rd_valid, sched_ready, capture_cnt, err
  );
endinterface

// File: rtl/aes256_round_key_store.sv
// Captures the 15 AES-256 round keys in strobe order, then serves them by round index.
// Read latency 1 cycle, one read per cycle; no backpressure, keys arrive on rk_in_valid strobes.
module aes256_round_key_store #(
  parameter int NUM_RK = 15,
  parameter int RK_W   = 128,
  parameter int IDX_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  aes256_round_key_store_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    READY
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RK - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [RK_W-1:0]  rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_en;
  logic             rd_ok;

  logic [RK_W-1:0]  key_mem [NUM_RK];

  // Reads are only honoured in READY, so they never alias an in-flight capture write.
  assign rd_ok = (state_q == READY) && (bus.rd_idx <= LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_en      = 1'b0;

    // load_start outranks a simultaneous key strobe: that key is dropped.
    if (bus.load_start) begin
      state_d = CAPTURE;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        CAPTURE: begin
          if (bus.rk_in_valid) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == LAST_IDX) begin
              state_d = READY;
            end
          end
        end
        IDLE, READY: begin
          if (bus.rk_in_valid) begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (bus.rd_en) begin
      rd_valid_d = 1'b1;
      if (rd_ok) begin
        rd_data_d = key_mem[bus.rd_idx];
      end else begin
        rd_data_d = '0;
        err_d     = 1'b1;
      end
    end
  end

  // Key storage carries no reset; rd_ok gates every read until a full schedule is present.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_mem[cnt_q] <= bus.rk_in;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.sched_ready = (state_q == READY);
  assign bus.capture_cnt = cnt_q;
  assign bus.err         = err_q;

endmodule
